uart_tx_seq: RTL
================

// Module: uart_tx_seq
// PURPOSE
//  Sequential front end of the UART transmitter. Accepts bytes over a valid/ready
//  handshake, buffers one byte and runs the baud-rate divider and frame state counter.
//  Drives r_state/r_data of uart_tx_comb, which maps them to the serial line.
//  Frame: IDLE(0) -> start(1) -> data bits LSB first (2..WIDTH+1) -> stop(LAST_STATE).
// PARAMETERS
//  WIDTH         8      data bits per frame
//  STATES_WIDTH  32     width of o_state; must match uart_tx_comb
//  CLKS_PER_BIT  868    i_clk cycles per serial bit, >=2
//  IDLE          0      idle state code
//  LAST_STATE    WIDTH+2  stop-bit state code
// PORTS
//  i_clk      in   1             system clock, all logic on rising edge
//  i_rst_n    in   1             asynchronous active-low reset
//  i_data     in   WIDTH         byte to send
//  i_valid    in   1             i_data valid
//  o_ready    out  1             block can accept i_data this cycle
//  o_state    out  STATES_WIDTH  frame state; feeds uart_tx_comb r_state
//  o_data     out  WIDTH         byte being shifted; feeds uart_tx_comb r_data
//  o_busy     out  1             frame in progress (o_state != IDLE) or hold full
// BEHAVIOUR
//  Reset (async assert, sync release): o_state=IDLE, o_data=0, baud count=0,
//   hold empty, o_busy=0. o_ready = !hold_valid, so it reads 1 during/after reset.
//  Transfer: accept on rising edge with i_valid && o_ready; i_data is sampled there.
//   A byte is never dropped or duplicated. Holding i_valid with o_ready=0 is a stall.
//  Shifter free = o_state==IDLE, or o_state==LAST_STATE with baud count==CLKS_PER_BIT-1.
//  Load priority on a free edge:
//   1. If hold is full: o_state<=1 and o_data<=hold; hold empties.
//   2. Else, if a transfer occurs: bypass. o_state<=1 and o_data<=i_data.
//   3. Else: o_state<=IDLE.
//   A transfer on the same edge as case 1 is impossible, because o_ready=0.
//  A transfer while the shifter is not free fills the hold register.
//  Latency: accepted at edge k on idle shifter -> o_state==1 after edge k.
//  Back-to-back: no idle cycle between the stop bit and the next start.
//  Baud counter counts 0..CLKS_PER_BIT-1 while o_state!=IDLE. It is held at 0 in IDLE
//   and clears on every state advance or load. Each state lasts exactly CLKS_PER_BIT
//   cycles. A frame therefore takes (WIDTH+2)*CLKS_PER_BIT cycles.
//  State advance: o_state increments 1..LAST_STATE at terminal count.
//   It never exceeds LAST_STATE, so uart_tx_comb's formal assert must never fire.
//  o_data is stable for the whole frame. It changes only on a load.
//  Reset mid-frame: the frame is abandoned and the hold byte is lost.
//   The line returns to idle-high through o_state=IDLE.
//  Counter width: $clog2(CLKS_PER_BIT); terminal compare at full width, no wrap.
// STRUCTURE
//  Shared include uart_defs.vh: UART_IDLE=0, UART_START=1, UART_FIRST_DATA=2,
//   and UART_LAST_STATE(WIDTH). This block and uart_tx_comb both use it.
//  One sub-module, uart_baud_tick. Inputs: i_clk, i_rst_n, i_clear, i_enable.
//   Output: o_tick, a pulse at terminal count.
//  Remaining logic: hold register and frame state/data registers.
// TESTING  (CLKS_PER_BIT=4, WIDTH=8; o_uart_tx taken through uart_tx_comb)
//  1 Reset idle: i_rst_n low 3 cycles, then release.
//    -> o_state=0, o_uart_tx=1, o_ready=1, o_busy=0.
//  2 Single byte: send 0xA5 at edge k.
//    -> o_state=1 after edge k.
//    -> o_uart_tx = 0,1,0,1,0,0,1,0,1,1, each level for 4 cycles.
//    -> o_state=0 after edge k+40.
//  3 Back-to-back: send 0x00, then 0xFF while frame 1 runs.
//    -> o_ready=0 from hold fill until frame 2 loads.
//    -> frame 2 start bit directly follows the stop bit, with no idle cycle.
//  4 Stall: hold full and i_valid held high with 0x3C.
//    -> no accept until o_ready returns.
//    -> 0x3C is transmitted exactly once.
//  5 Free-edge bypass: present i_valid with 0x81 on the last stop cycle, hold empty.
//    -> accepted, and o_state=1 on the next cycle.
//  6 Mid-frame reset: assert i_rst_n low at o_state=5 for 1 cycle.
//    -> o_state=0 immediately (async), hold empty, o_uart_tx=1.
//    -> no partial frame resumes.

Source files
------------

// File: rtl/uart_tx_seq_pkg.sv
// Shared definitions for the UART transmit sequencer.
//   UART_IDLE / UART_START / UART_FIRST_DATA : fixed frame state codes
//   uart_last_state(width)                   : stop-bit state code for a given data width
//   load_sel_e                               : what the frame registers load on a free edge
package uart_tx_seq_pkg;

  localparam int UART_IDLE       = 0;
  localparam int UART_START      = 1;
  localparam int UART_FIRST_DATA = 2;

  function automatic int uart_last_state(input int width);
    return UART_FIRST_DATA + width;
  endfunction

  typedef enum logic [1:0] {
    LOAD_NONE   = 2'd0,
    LOAD_HOLD   = 2'd1,
    LOAD_BYPASS = 2'd2
  } load_sel_e;

endpackage

// File: rtl/uart_tx_seq_baud_tick.sv
// Baud-rate divider for the UART transmit sequencer.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_clear  : restart the bit period (frame load)
//   i_enable : count while a frame is in progress, otherwise held at 0
//   o_tick   : one-cycle pulse on the last cycle of each bit period
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tc;

  // Full-width compare: the counter never wraps on its own, even when
  // CLKS_PER_BIT is not a power of two.
  assign tc     = (cnt_q == CNT_TC);
  assign o_tick = i_enable && tc;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear || !i_enable || tc) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_seq.sv
// Sequential front end of the UART transmitter: one-byte hold buffer,
// baud divider and frame state counter. o_state/o_data drive the
// combinational line mapper (IDLE -> start -> data LSB first -> stop).
//   i_clk   : system clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   i_data  : byte to send, sampled on an accepting edge
//   i_valid : i_data valid
//   o_ready : a byte can be accepted this cycle (hold empty)
//   o_state : frame state code
//   o_data  : byte being shifted, stable for the whole frame
//   o_busy  : frame in progress or hold full
module uart_tx_seq
  import uart_tx_seq_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int STATES_WIDTH = 32,
  parameter int CLKS_PER_BIT = 868,
  parameter int IDLE         = UART_IDLE,
  parameter int LAST_STATE   = uart_last_state(WIDTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [STATES_WIDTH-1:0] o_state,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_busy
);

  localparam logic [STATES_WIDTH-1:0] ST_IDLE  = STATES_WIDTH'(IDLE);
  localparam logic [STATES_WIDTH-1:0] ST_START = STATES_WIDTH'(UART_START);
  localparam logic [STATES_WIDTH-1:0] ST_LAST  = STATES_WIDTH'(LAST_STATE);

  logic [STATES_WIDTH-1:0] state_q, state_d;
  logic [WIDTH-1:0]        data_q, data_d;
  logic [WIDTH-1:0]        hold_q, hold_d;
  logic                    hold_valid_q, hold_valid_d;

  logic      tick;
  logic      free;
  logic      xfer;
  logic      load;
  load_sel_e load_sel;

  assign o_ready = !hold_valid_q;
  assign o_state = state_q;
  assign o_data  = data_q;
  assign o_busy  = (state_q != ST_IDLE) || hold_valid_q;

  assign xfer = i_valid && o_ready;

  // The shifter is free when idle or on the final cycle of the stop bit,
  // so a waiting byte starts with no idle gap after the previous frame.
  assign free = (state_q == ST_IDLE) || ((state_q == ST_LAST) && tick);

  always_comb begin
    load_sel = LOAD_NONE;
    if (free) begin
      if (hold_valid_q) begin
        load_sel = LOAD_HOLD;
      end else if (xfer) begin
        load_sel = LOAD_BYPASS;
      end
    end
  end

  assign load = (load_sel != LOAD_NONE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_tick (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (load),
    .i_enable (state_q != ST_IDLE),
    .o_tick   (tick)
  );

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;

    if (free) begin
      unique case (load_sel)
        LOAD_HOLD: begin
          state_d      = ST_START;
          data_d       = hold_q;
          hold_valid_d = 1'b0;
        end
        LOAD_BYPASS: begin
          state_d = ST_START;
          data_d  = i_data;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end else begin
      if (tick) begin
        state_d = state_q + STATES_WIDTH'(1);
      end
      // Hold is empty whenever xfer is true, so this never overwrites a byte.
      if (xfer) begin
        hold_d       = i_data;
        hold_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      data_q       <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

endmodule
